// File: rtl/iob_bus_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : iob_bus_arbiter_pkg                                        |
// | Description : Shared constants and helpers for the two-master IOb bus    |
// |               arbiter: FSM state encodings, master indices, bus widths   |
// |               and winner-to-state mapping.                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package iob_bus_arbiter_pkg;

    // FSM state encodings (2-bit state register)
    localparam logic [1:0] c_ARB_IDLE = 2'd0;
    localparam logic [1:0] c_ARB_OWN0 = 2'd1;
    localparam logic [1:0] c_ARB_OWN1 = 2'd2;

    // Master indices, as stored in the last-owner register
    localparam logic c_ARB_M0 = 1'b0;
    localparam logic c_ARB_M1 = 1'b1;

    // Request bus is {valid, addr, wdata, wstrb}
    function automatic int req_width(input int aw, input int dw);
        return 1 + aw + dw + dw / 8;
    endfunction

    // Response bus is {rdata, ready}
    function automatic int resp_width(input int dw);
        return dw + 1;
    endfunction

    // One-hot winner {m1, m0} to the owning state; no winner means IDLE
    function automatic logic [1:0] win_to_state(input logic [1:0] win);
        logic [1:0] st;
        st = c_ARB_IDLE;
        if (win[1]) begin
            st = c_ARB_OWN1;
        end else if (win[0]) begin
            st = c_ARB_OWN0;
        end
        return st;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_arb_sel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : iob_arb_sel                                                |
// | Description : Combinational winner selection between two masters.       |
// |               A lone requester always wins. With both requesting, the    |
// |               master not equal to 'last' wins when rr_en is set,         |
// |               otherwise master 1 wins.                                   |
// | Ports       : valid0, valid1 - request valids of master 0 / master 1     |
// |               last           - index of the most recent owner            |
// |               rr_en          - alternate on contention instead of fixed  |
// |               winner         - one-hot {m1, m0}, 2'b00 when none valid   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module iob_arb_sel
    import iob_bus_arbiter_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last,
    input  logic       rr_en,
    output logic [1:0] winner
);

    always_comb begin
        winner = 2'b00;
        if (valid0 && valid1) begin
            if (rr_en && (last == c_ARB_M1)) begin
                winner = 2'b01;
            end else begin
                winner = 2'b10;
            end
        end else if (valid1) begin
            winner = 2'b10;
        end else if (valid0) begin
            winner = 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/iob_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : iob_bus_arbiter                                            |
// | Description : Two-master to one-slave arbiter for the native IOb         |
// |               concatenated buses. m0 (instruction) and m1 (data) share   |
// |               one memory port s. The grant is registered and held from   |
// |               grant until the slave returns ready.                       |
// | Ports       : clk, rst  - clock, synchronous active-high reset           |
// |               m0_req    - in  {valid, addr, wdata, wstrb}                |
// |               m0_resp   - out {rdata, ready}                             |
// |               m1_req    - in  data master request                        |
// |               m1_resp   - out data master response                       |
// |               s_req     - out merged request to memory                   |
// |               s_resp    - in  memory response                            |
// |               grant     - out one-hot owner {m1, m0}, 2'b00 when idle    |
// | Options     : IOB_BUS_ARB_RR_EN - round-robin on contention; when        |
// |               undefined, fixed priority m1 over m0.                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module iob_bus_arbiter
    import iob_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [req_width(ADDR_W, DATA_W)-1:0]  m0_req,
    output logic [resp_width(DATA_W)-1:0]         m0_resp,
    input  logic [req_width(ADDR_W, DATA_W)-1:0]  m1_req,
    output logic [resp_width(DATA_W)-1:0]         m1_resp,
    output logic [req_width(ADDR_W, DATA_W)-1:0]  s_req,
    input  logic [resp_width(DATA_W)-1:0]         s_resp,
    output logic [1:0]                            grant
);

    localparam int c_VALID_BIT = req_width(ADDR_W, DATA_W) - 1;

`ifdef IOB_BUS_ARB_RR_EN
    localparam logic c_RR_EN = 1'b1;
    logic r_last;
`else
    localparam logic c_RR_EN = 1'b0;
`endif

    logic [1:0] r_state;
    logic       w_last;
    logic       w_m0_valid;
    logic       w_m1_valid;
    logic       w_ready;
    logic       w_owner;
    logic       w_own_valid;
    logic [1:0] w_idle_win;
    logic [1:0] w_done_win;

    assign w_m0_valid  = m0_req[c_VALID_BIT];
    assign w_m1_valid  = m1_req[c_VALID_BIT];
    assign w_ready     = s_resp[0];
    assign w_owner     = (r_state == c_ARB_OWN1) ? c_ARB_M1 : c_ARB_M0;
    assign w_own_valid = w_owner ? w_m1_valid : w_m0_valid;

`ifdef IOB_BUS_ARB_RR_EN
    assign w_last = r_last;
`else
    assign w_last = c_ARB_M0;
`endif

    // Arbitration from IDLE
    iob_arb_sel u_idle_sel (
        .valid0 (w_m0_valid),
        .valid1 (w_m1_valid),
        .last   (w_last),
        .rr_en  (c_RR_EN),
        .winner (w_idle_win)
    );

    // Arbitration at completion: treating the finishing owner as 'last' with
    // alternation forced on hands the bus straight to a waiting other master,
    // and otherwise to the owner itself if it has already raised a new request.
    iob_arb_sel u_done_sel (
        .valid0 (w_m0_valid),
        .valid1 (w_m1_valid),
        .last   (w_owner),
        .rr_en  (1'b1),
        .winner (w_done_win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ARB_IDLE;
`ifdef IOB_BUS_ARB_RR_EN
            r_last  <= c_ARB_M0;
`endif
        end else begin
            case (r_state)
                c_ARB_IDLE: begin
                    // Slave ready here is spurious and deliberately ignored
                    r_state <= win_to_state(w_idle_win);
                end
                c_ARB_OWN0, c_ARB_OWN1: begin
                    if (w_ready) begin
                        r_state <= win_to_state(w_done_win);
`ifdef IOB_BUS_ARB_RR_EN
                        r_last  <= w_owner;
`endif
                    end else if (!w_own_valid) begin
                        // Owner withdrew before ready: abandon the transaction
                        r_state <= c_ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ARB_IDLE;
                end
            endcase
        end
    end

    assign grant = {(r_state == c_ARB_OWN1), (r_state == c_ARB_OWN0)};

    // Routing depends only on the registered state, so no request reaches
    // s_req until the cycle after it is granted.
    always_comb begin
        s_req   = '0;
        m0_resp = '0;
        m1_resp = '0;
        case (r_state)
            c_ARB_OWN0: begin
                s_req   = m0_req;
                m0_resp = s_resp;
            end
            c_ARB_OWN1: begin
                s_req   = m1_req;
                m1_resp = s_resp;
            end
            default: begin
                s_req   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire
